// File: rtl/window_buffer_5x5.sv
// window_buffer_5x5
// Turns a raster-order pixel stream into a 5x5 sliding window. Four
// chained line buffers supply rows r-4..r-1 at the current column, and
// pixel_in supplies row r. Windows are flagged valid only where all 25
// taps belong to the current frame (row >= 4, col >= 4).
module window_buffer_5x5 #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic signed [7:0] pixel_in,
    output logic signed [7:0] data_out_0,
    output logic signed [7:0] data_out_1,
    output logic signed [7:0] data_out_2,
    output logic signed [7:0] data_out_3,
    output logic signed [7:0] data_out_4,
    output logic signed [7:0] data_out_5,
    output logic signed [7:0] data_out_6,
    output logic signed [7:0] data_out_7,
    output logic signed [7:0] data_out_8,
    output logic signed [7:0] data_out_9,
    output logic signed [7:0] data_out_10,
    output logic signed [7:0] data_out_11,
    output logic signed [7:0] data_out_12,
    output logic signed [7:0] data_out_13,
    output logic signed [7:0] data_out_14,
    output logic signed [7:0] data_out_15,
    output logic signed [7:0] data_out_16,
    output logic signed [7:0] data_out_17,
    output logic signed [7:0] data_out_18,
    output logic signed [7:0] data_out_19,
    output logic signed [7:0] data_out_20,
    output logic signed [7:0] data_out_21,
    output logic signed [7:0] data_out_22,
    output logic signed [7:0] data_out_23,
    output logic signed [7:0] data_out_24,
    output logic              valid_out_buf,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // lb[k][0] is the newest entry; lb[k][IMG_W-1] is the tap for row r-1-k.
    logic signed [7:0] lb  [4][IMG_W];
    logic signed [7:0] win [5][5];

    logic last_col;
    logic last_row;
    logic in_valid_region;

    assign last_col        = (col == CW'(IMG_W - 1));
    assign last_row        = (row == RW'(IMG_H - 1));
    assign in_valid_region = (row >= RW'(4)) && (col >= CW'(4));

    // Raster position of the next accepted pixel; wraps at end of frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (valid_in) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Line buffers: contents are masked by validity gating, so no reset.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            lb[0][0] <= pixel_in;
            for (int k = 1; k < 4; k++) begin
                lb[k][0] <= lb[k-1][IMG_W-1];
            end
            for (int k = 0; k < 4; k++) begin
                for (int i = 1; i < IMG_W; i++) begin
                    lb[k][i] <= lb[k][i-1];
                end
            end
        end
    end

    // Window shifts left one column per accepted pixel; column 4 takes the new column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 5; j++) begin
                    win[i][j] <= '0;
                end
            end
        end else if (valid_in) begin
            for (int i = 0; i < 5; i++) begin
                for (int j = 0; j < 4; j++) begin
                    win[i][j] <= win[i][j+1];
                end
            end
            win[0][4] <= lb[3][IMG_W-1];
            win[1][4] <= lb[2][IMG_W-1];
            win[2][4] <= lb[1][IMG_W-1];
            win[3][4] <= lb[0][IMG_W-1];
            win[4][4] <= pixel_in;
        end
    end

    // Validity and end-of-frame flags, one cycle per accepted pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out_buf <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            valid_out_buf <= valid_in && in_valid_region;
            frame_done    <= valid_in && last_row && last_col;
        end
    end

    assign data_out_0  = win[0][0];
    assign data_out_1  = win[0][1];
    assign data_out_2  = win[0][2];
    assign data_out_3  = win[0][3];
    assign data_out_4  = win[0][4];
    assign data_out_5  = win[1][0];
    assign data_out_6  = win[1][1];
    assign data_out_7  = win[1][2];
    assign data_out_8  = win[1][3];
    assign data_out_9  = win[1][4];
    assign data_out_10 = win[2][0];
    assign data_out_11 = win[2][1];
    assign data_out_12 = win[2][2];
    assign data_out_13 = win[2][3];
    assign data_out_14 = win[2][4];
    assign data_out_15 = win[3][0];
    assign data_out_16 = win[3][1];
    assign data_out_17 = win[3][2];
    assign data_out_18 = win[3][3];
    assign data_out_19 = win[3][4];
    assign data_out_20 = win[4][0];
    assign data_out_21 = win[4][1];
    assign data_out_22 = win[4][2];
    assign data_out_23 = win[4][3];
    assign data_out_24 = win[4][4];

endmodule

// File: tb/tb_window_buffer_5x5.sv
// Bench for window_buffer_5x5: a raster-position model pushes the expected
// window for every valid position; the monitor pops and compares on each
// valid_out_buf pulse.
module tb_window_buffer_5x5;

    localparam int W = 28;
    localparam int H = 28;

    logic              clk;
    logic              rst_n;
    logic              valid_in;
    logic signed [7:0] pixel_in;
    logic signed [7:0] d [25];
    logic              valid_out_buf;
    logic              frame_done;

    window_buffer_5x5 #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .pixel_in(pixel_in),
        .data_out_0(d[0]),   .data_out_1(d[1]),   .data_out_2(d[2]),   .data_out_3(d[3]),
        .data_out_4(d[4]),   .data_out_5(d[5]),   .data_out_6(d[6]),   .data_out_7(d[7]),
        .data_out_8(d[8]),   .data_out_9(d[9]),   .data_out_10(d[10]), .data_out_11(d[11]),
        .data_out_12(d[12]), .data_out_13(d[13]), .data_out_14(d[14]), .data_out_15(d[15]),
        .data_out_16(d[16]), .data_out_17(d[17]), .data_out_18(d[18]), .data_out_19(d[19]),
        .data_out_20(d[20]), .data_out_21(d[21]), .data_out_22(d[22]), .data_out_23(d[23]),
        .data_out_24(d[24]),
        .valid_out_buf(valid_out_buf), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [199:0] w;
        int           r;
        int           c;
    } exp_t;

    exp_t         q[$];
    int           checks   = 0;
    int           failures = 0;
    int           total_valid = 0;
    int           mr = 0, mc = 0;
    logic         exp_vld = 1'b0;
    logic         exp_fd  = 1'b0;
    logic         last_acc = 1'b0;
    logic [199:0] first_win = '0;
    logic [199:0] last_win  = '0;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        return 8'((r * W + c) % 256);
    endfunction

    function automatic logic [199:0] window_at(input int r, input int c);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[8*(5*i+j) +: 8] = pix(r - 4 + i, c - 4 + j);
        return w;
    endfunction

    // Reference raster model, updated on the same edge the DUT samples.
    always @(posedge clk) begin
        if (!rst_n) begin
            mr = 0; mc = 0; exp_vld = 1'b0; exp_fd = 1'b0;
            q.delete();
        end else if (valid_in) begin
            exp_vld = (mr >= 4) && (mc >= 4);
            exp_fd  = (mr == H - 1) && (mc == W - 1);
            if (exp_vld) q.push_back('{window_at(mr, mc), mr, mc});
            if (mc == W - 1) begin
                mc = 0;
                mr = (mr == H - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end else begin
            exp_vld = 1'b0;
            exp_fd  = 1'b0;
        end
        last_acc = valid_in && rst_n;
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [199:0] obs;
        exp_t e;
        for (int k = 0; k < 25; k++) obs[8*k +: 8] = d[k];
        if (!rst_n) begin
            chk("reset_outputs", {obs[197:0], valid_out_buf, frame_done}, '0);
        end else begin
            chk("valid_out_buf", 200'(valid_out_buf), 200'(exp_vld));
            chk("frame_done", 200'(frame_done), 200'(exp_fd));
            if (!last_acc) chk("idle_no_valid", 200'(valid_out_buf), '0);
            if (valid_out_buf) begin
                total_valid++;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk($sformatf("window_r%0d_c%0d", e.r, e.c), obs, e.w);
                    if (e.r == 4 && e.c == 4) first_win = obs;
                    if (e.r == H - 1 && e.c == W - 1) last_win = obs;
                end else begin
                    chk("window_queue_size", 200'(q.size()), 200'(1));
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] p);
        valid_in = v;
        pixel_in = p;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_frame(input bit gapped);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gapped && $urandom_range(0, 1) == 1) drive(1'b0, 8'($urandom));
                drive(1'b1, pix(r, c));
            end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'($urandom));
    endtask

    initial begin
        int base;
        rst_n = 1'b0;
        valid_in = 1'b0;
        pixel_in = '0;

        // Reset held: random pixels must not disturb outputs.
        for (int i = 0; i < 6; i++) drive(1'b1, 8'($urandom));
        rst_n = 1'b1;
        idle(2);

        // Continuous frame.
        base = total_valid;
        stream_frame(1'b0);
        idle(3);
        chk("frame1_count", 200'(total_valid - base), 200'(576));
        chk("first_d0",  200'(first_win[7:0]),     200'(8'd0));
        chk("first_d12", 200'(first_win[103:96]),  200'(8'd58));
        chk("first_d24", 200'(first_win[199:192]), 200'(8'd116));
        chk("last_d0",   200'(last_win[7:0]),      200'(8'h9B));
        chk("last_d24",  200'(last_win[199:192]),  200'(8'd15));

        // Gapped frame.
        base = total_valid;
        stream_frame(1'b1);
        idle(3);
        chk("gapped_count", 200'(total_valid - base), 200'(576));

        // Mid-frame reset at (10,7), then a full frame.
        for (int r = 0; r <= 10; r++)
            for (int c = 0; c < W; c++)
                if (r < 10 || c < 7) drive(1'b1, pix(r, c));
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, pix(10, 7));
        rst_n = 1'b1;
        base = total_valid;
        stream_frame(1'b0);
        idle(3);
        chk("post_reset_count", 200'(total_valid - base), 200'(576));

        // Two frames back to back.
        base = total_valid;
        stream_frame(1'b0);
        stream_frame(1'b0);
        idle(3);
        chk("b2b_count", 200'(total_valid - base), 200'(1152));
        chk("queue_drained", 200'(q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
